// File: rtl/link_tx_framer.sv
// Nibble-serial link transmit framer: buffers 32-bit words in a small FIFO and
// sends each word as a 10-nibble frame (header, 8 data nibbles, XOR checksum).
module link_tx_framer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [3:0]  HDR_NIBBLE = 4'hA
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        rdy_from_recv,
    output logic [3:0]  tx_nibble,
    output logic        tx_valid,
    output logic        busy,
    output logic [15:0] frames_sent,
    output logic        overflow
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW     = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } state_t;

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic              push;
    logic              pop;
    logic              fifo_nonempty;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] word_shl;
    logic [NIB_W-1:0]  csum;
    logic [NIB_W-1:0]  tx_nibble_nxt;
    logic              tx_valid_nxt;

    // Readiness follows the registered count and is forced low while in reset.
    assign in_ready      = !RST && (count < CW'(FIFO_DEPTH));
    assign push          = in_valid && in_ready;
    assign fifo_nonempty = (count != '0);

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
        end
    end

    // Frame word is captured from the FIFO head on every pop.
    always_ff @(posedge CLK) begin
        if (RST) begin
            word <= '0;
        end else if (pop) begin
            word <= mem[rd_ptr];
        end
    end

    assign word_shl = word << {idx_nxt, 2'b00};

    always_comb begin
        csum = '0;
        for (int i = 0; i < 8; i++) begin
            csum = csum ^ word[i*NIB_W +: NIB_W];
        end
    end

    // Next state plus the nibble that will be on the wire once that state is entered.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        pop           = 1'b0;
        tx_nibble_nxt = '0;
        tx_valid_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (fifo_nonempty && rdy_from_recv) begin
                    state_nxt = HDR;
                    pop       = 1'b1;
                end
            end
            HDR: begin
                state_nxt = DATA;
                idx_nxt   = '0;
            end
            DATA: begin
                if (idx == IDX_W'(7)) begin
                    state_nxt = CSUM;
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
            end
            CSUM: begin
                if (fifo_nonempty && rdy_from_recv) begin
                    state_nxt = HDR;
                    pop       = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        case (state_nxt)
            HDR: begin
                tx_nibble_nxt = HDR_NIBBLE;
                tx_valid_nxt  = 1'b1;
            end
            DATA: begin
                tx_nibble_nxt = word_shl[WORD_W-1 -: NIB_W];
                tx_valid_nxt  = 1'b1;
            end
            CSUM: begin
                tx_nibble_nxt = csum;
                tx_valid_nxt  = 1'b1;
            end
            default: begin
                tx_nibble_nxt = '0;
                tx_valid_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            idx         <= '0;
            tx_nibble   <= '0;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            frames_sent <= '0;
            overflow    <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            tx_nibble <= tx_nibble_nxt;
            tx_valid  <= tx_valid_nxt;
            busy      <= (state_nxt != IDLE) || (count_nxt != '0);
            if (state == CSUM) begin
                frames_sent <= frames_sent + CNT_W'(1);
            end
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_link_tx_framer.sv
// Self-checking bench for link_tx_framer: vector table, directed corner cases
// and a randomized run against a queue-based frame model.
module tb_link_tx_framer;

    localparam int         DEPTH = 4;
    localparam logic [3:0] HDRN  = 4'hA;

    logic        CLK;
    logic        RST;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        rdy_from_recv;
    logic [3:0]  tx_nibble;
    logic        tx_valid;
    logic        busy;
    logic [15:0] frames_sent;
    logic        overflow;

    link_tx_framer #(.FIFO_DEPTH(DEPTH), .HDR_NIBBLE(HDRN)) dut (
        .CLK(CLK),
        .RST(RST),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .rdy_from_recv(rdy_from_recv),
        .tx_nibble(tx_nibble),
        .tx_valid(tx_valid),
        .busy(busy),
        .frames_sent(frames_sent),
        .overflow(overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // Reference model: queue of pending words, position of the nibble on the wire.
    logic [31:0] mq[$];
    int          pos = 0;
    logic [3:0]  mframe[10];
    logic [15:0] mframes = 16'h0;
    logic        movf = 1'b0;

    logic        lv[$];
    logic [3:0]  ln[$];

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        r;
        logic        ev;
        logic [3:0]  en;
        logic        eb;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cycle);
        end
    endtask

    task automatic model_step(input logic v, input logic [31:0] d, input logic r, input logic rs);
        logic        acc;
        logic        start;
        logic [31:0] w;
        logic [3:0]  x;
        if (rs) begin
            mq.delete();
            pos     = 0;
            mframes = 16'h0;
            movf    = 1'b0;
            return;
        end
        acc = v && (mq.size() < DEPTH);
        if (v && !acc) movf = 1'b1;
        start = (pos == 0 || pos == 10) && (mq.size() > 0) && r;
        if (pos == 10) mframes = mframes + 16'h1;
        if (start) begin
            w = mq.pop_front();
            x = 4'h0;
            mframe[0] = HDRN;
            for (int k = 0; k < 8; k++) begin
                mframe[k+1] = 4'((w >> (28 - 4*k)) & 32'hF);
                x = x ^ mframe[k+1];
            end
            mframe[9] = x;
            pos = 1;
        end else if (pos == 0 || pos == 10) begin
            pos = 0;
        end else begin
            pos = pos + 1;
        end
        if (acc) mq.push_back(d);
    endtask

    // Apply inputs at a falling edge, advance one clock, compare all outputs with the model.
    task automatic cyc(input logic v, input logic [31:0] d, input logic r, input logic rs);
        logic [23:0] e_vec;
        logic [23:0] a_vec;
        logic        ev;
        logic [3:0]  en;
        in_valid      = v;
        in_data       = d;
        rdy_from_recv = r;
        RST           = rs;
        model_step(v, d, r, rs);
        @(negedge CLK);
        cycle++;
        ev    = (pos != 0);
        en    = ev ? mframe[pos-1] : 4'h0;
        e_vec = {(!rs && (mq.size() < DEPTH)), (ev || (mq.size() != 0)), movf, ev, en, mframes};
        a_vec = {in_ready, busy, overflow, tx_valid, tx_nibble, frames_sent};
        chk("model", 32'(a_vec), 32'(e_vec));
        lv.push_back(tx_valid);
        ln.push_back(tx_nibble);
    endtask

    task automatic do_reset();
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        chk("post_rst", 32'({in_ready, busy, tx_valid, tx_nibble, overflow, frames_sent}),
            32'({1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 16'h0}));
        lv.delete();
        ln.delete();
    endtask

    function automatic int first_valid();
        for (int i = 0; i < lv.size(); i++) begin
            if (lv[i]) return i;
        end
        return -1;
    endfunction

    function automatic int count_valid();
        int n = 0;
        for (int i = 0; i < lv.size(); i++) begin
            if (lv[i]) n++;
        end
        return n;
    endfunction

    initial begin
        int f;
        int n;
        in_valid      = 1'b0;
        in_data       = 32'h0;
        rdy_from_recv = 1'b0;
        RST           = 1'b1;
        @(negedge CLK);

        // Single frame of 0x12345678: vector table
        tbl[0] = '{1'b1, 32'h12345678, 1'b1, 1'b0, 4'h0, 1'b1};
        tbl[1] = '{1'b0, 32'h0, 1'b1, 1'b1, HDRN, 1'b1};
        for (int k = 0; k < 8; k++) tbl[2+k] = '{1'b0, 32'h0, 1'b1, 1'b1, 4'(k + 1), 1'b1};
        tbl[10] = '{1'b0, 32'h0, 1'b1, 1'b1, 4'h8, 1'b1};
        tbl[11] = '{1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 1'b0};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0);
            chk("tbl_valid", 32'(tx_valid), 32'(tbl[i].ev));
            chk("tbl_nibble", 32'(tx_nibble), 32'(tbl[i].en));
            chk("tbl_busy", 32'(busy), 32'(tbl[i].eb));
        end
        chk("tbl_frames", 32'(frames_sent), 32'h1);

        // Four back-to-back words
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, $urandom, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        f = first_valid();
        chk("b2b_first", 32'(f), 32'd1);
        chk("b2b_count", 32'(count_valid()), 32'd40);
        if (f >= 0 && f + 40 < lv.size()) begin
            chk("b2b_last", 32'({lv[f+39], lv[f+40]}), 32'h2);
            for (int k = 0; k < 4; k++) chk("b2b_hdr", 32'(ln[f+10*k]), 32'(HDRN));
        end
        chk("b2b_frames", 32'(frames_sent), 32'd4);

        // Receiver not ready: fill FIFO, overflow, then drain
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0);
        chk("full_ovf", 32'(overflow), 32'h1);
        chk("full_ready", 32'(in_ready), 32'h0);
        chk("full_novalid", 32'(count_valid()), 32'd0);
        lv.delete();
        ln.delete();
        for (int i = 0; i < 60; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain_count", 32'(count_valid()), 32'd40);
        chk("drain_frames", 32'(frames_sent), 32'd4);
        chk("drain_ovf_sticky", 32'(overflow), 32'h1);

        // rdy_from_recv drops mid-frame
        do_reset();
        cyc(1'b1, 32'hFFFF0000, 1'b1, 1'b0);
        cyc(1'b1, 32'h13579BDF, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0);
        chk("drop_hdr", 32'({lv[1], ln[1]}), 32'({1'b1, HDRN}));
        chk("drop_csum", 32'({lv[10], ln[10]}), 32'h10);
        n = 0;
        for (int i = 11; i < lv.size(); i++) if (lv[i]) n++;
        chk("drop_wait", 32'(n), 32'd0);
        chk("drop_frames", 32'(frames_sent), 32'd1);
        chk("drop_busy", 32'(busy), 32'h1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drop_restart", 32'({tx_valid, tx_nibble}), 32'({1'b1, HDRN}));
        for (int i = 0; i < 12; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0);

        // Reset in the middle of a frame with two words queued
        do_reset();
        cyc(1'b1, 32'hCAFE1234, 1'b1, 1'b0);
        cyc(1'b1, 32'h0BADF00D, 1'b1, 1'b0);
        cyc(1'b1, 32'h55AA55AA, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("mid_5th", 32'({tx_valid, tx_nibble}), 32'h1E);
        cyc(1'b0, 32'h0, 1'b1, 1'b1);
        chk("mid_rst_valid", 32'(tx_valid), 32'h0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("mid_after", 32'({in_ready, busy, frames_sent}), 32'({1'b1, 1'b0, 16'h0}));
        lv.delete();
        ln.delete();
        for (int i = 0; i < 30; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("mid_nomore", 32'(count_valid()), 32'd0);
        chk("mid_frames", 32'(frames_sent), 32'h0);

        // frames_sent wrap
        do_reset();
        force dut.frames_sent = 16'hFFFF;
        mframes = 16'hFFFF;
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        release dut.frames_sent;
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("wrap_pre", 32'(frames_sent), 32'hFFFF);
        cyc(1'b1, 32'h89ABCDEF, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("wrap_post", 32'(frames_sent), 32'h0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom % 2), $urandom, 1'(($urandom % 4) != 0), 1'(($urandom % 400) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/link_tx_framer.md
LINK_TX_FRAMER -- requirements
Module: link_tx_framer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, sets the input word FIFO depth (power of 2, at least 2).
REQ-002 Parameter HDR_NIBBLE, default 4'hA, sets the frame start nibble.
REQ-003 CLK  input  1  is the single clock; all logic is on its rising edge.
REQ-004 RST  input  1  is a synchronous, active-high reset.
REQ-005 in_data  input  32  is the word to send, from the Nios/Avalon write path.
REQ-006 in_valid  input  1  signals that in_data is valid this cycle.
REQ-007 in_ready  output  1  signals that the block can accept a word this cycle.
REQ-008 rdy_from_recv  input  1  is the far-FPGA receiver-ready level, already synchronised to CLK.
REQ-009 tx_nibble  output  4  is the nibble toward the LVDS transmitter.
REQ-010 tx_valid  output  1  marks tx_nibble as a frame nibble this cycle.
REQ-011 busy  output  1  is high whenever the FSM is not IDLE or the FIFO is non-empty.
REQ-012 frames_sent  output  16  counts completed frames.
REQ-013 overflow  output  1  is a sticky flag: set when in_valid=1 and in_ready=0.

Function
REQ-014 A push SHALL occur when in_valid=1 and in_ready=1; in_ready SHALL equal (FIFO count < FIFO_DEPTH), using the registered count.
REQ-015 A frame SHALL be 10 consecutive nibbles, one per cycle with tx_valid=1:
  - 1: HDR_NIBBLE;
  - 2-9: the 8 data nibbles, in_data[31:28] first;
  - 10: checksum = XOR of the 8 data nibbles.
REQ-016 The FSM states SHALL be IDLE, HDR, DATA (8 cycles, 3-bit index), CSUM; tx_nibble and tx_valid SHALL be registered.
REQ-017 IDLE -> HDR when the FIFO is non-empty and rdy_from_recv=1; the FIFO head SHALL be popped into the shift register on that edge.
REQ-018 HDR -> DATA after 1 cycle; DATA -> CSUM after 8 cycles.
REQ-019 CSUM -> HDR (back-to-back, pop on that edge) if the FIFO is non-empty and rdy_from_recv=1; otherwise CSUM -> IDLE.
REQ-020 rdy_from_recv SHALL be sampled only at frame start; deassertion mid-frame SHALL NOT stall or abort the frame.
REQ-021 Latency: a push on edge t into an empty FIFO in IDLE, with rdy_from_recv=1, SHALL produce the header in cycle t+2 and the checksum in cycle t+11.
REQ-022 In IDLE, tx_valid SHALL be 0 and tx_nibble SHALL be 4'h0.
REQ-023 frames_sent SHALL increment on each CSUM cycle and wrap from 16'hFFFF to 0.
REQ-024 Push and pop on the same edge SHALL leave the count unchanged; a push is never accepted while full, even with a simultaneous pop.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-026 Rejected words SHALL be dropped; overflow stays set until RST.

Reset
REQ-027 When RST=1 on an edge, the following SHALL clear, regardless of state, mid-frame included:
  - FSM to IDLE;
  - FIFO emptied (pointers and count = 0);
  - tx_valid=0, tx_nibble=0;
  - frames_sent=0, overflow=0.
REQ-028 During RST, in_ready SHALL be 0; in the cycle after RST deasserts, in_ready SHALL be 1 and busy SHALL be 0.
REQ-029 A frame interrupted by RST SHALL NOT be resumed or counted.

Verification
REQ-030 Push 0x12345678 with rdy_from_recv=1 -> tx_nibble sequence A,1,2,3,4,5,6,7,8,8 in cycles t+2..t+11; frames_sent=1.
REQ-031 Push 4 words back-to-back with rdy_from_recv held at 1 -> 40 contiguous tx_valid cycles; 4 headers 10 cycles apart; frames_sent=4.
REQ-032 Hold rdy_from_recv=0, push 5 words -> 4 accepted, overflow=1, tx_valid stays 0.
  - Then raise rdy_from_recv -> exactly 4 frames are sent.
REQ-033 Drop rdy_from_recv during the DATA nibbles of word 0xFFFF0000 -> the frame completes with checksum 0.
  - The next frame waits until rdy_from_recv=1.
REQ-034 Assert RST for 1 cycle at the 5th nibble with 2 words queued -> tx_valid=0 next cycle, FIFO empty, frames_sent=0, no further frames.
REQ-035 Preload frames_sent to 16'hFFFF (force) and send 1 frame -> frames_sent=0.
